// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch controller with a single-line buffer. A miss refills one
// whole line from instruction memory, one word per MemAck.
module ins_fetch_ctrl #(
    parameter int dataW     = 32,
    parameter int LineWords = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] ProgAddr,
    input  logic             Flush,
    input  logic             MemAck,
    input  logic [dataW-1:0] MemData,
    output logic             MemReq,
    output logic [dataW-1:0] MemAddr,
    output logic [dataW-1:0] Instruction,
    output logic             InsValid,
    output logic             InsCacheStall
);

    localparam int IdxW = $clog2(LineWords);
    localparam int TagW = dataW - IdxW - 2;

    typedef enum logic {
        IDLE,
        FILL
    } stateT;

    stateT             state, nextState;
    logic [TagW-1:0]   addrTag, tagReg, fillTag;
    logic [IdxW-1:0]   wordIdx, count;
    logic              valid, hit;
    logic              startFill, wordAck, lastWord, clearValid;
    logic [dataW-1:0]  lineMem [LineWords];

    // Byte-offset bits never select anything; instructions are word aligned.
    logic unusedAddrBits;
    assign unusedAddrBits = ^ProgAddr[1:0];

    assign addrTag = ProgAddr[dataW-1:IdxW+2];
    assign wordIdx = ProgAddr[IdxW+1:2];
    assign hit     = valid && (tagReg == addrTag) && (state == IDLE);

    assign InsValid      = hit;
    assign InsCacheStall = !hit;
    assign Instruction   = hit ? lineMem[wordIdx] : '0;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        nextState  = state;
        startFill  = 1'b0;
        wordAck    = 1'b0;
        lastWord   = 1'b0;
        clearValid = 1'b0;
        MemReq     = 1'b0;
        MemAddr    = '0;
        case (state)
            IDLE: begin
                if (Flush) begin
                    clearValid = 1'b1;
                end else if (!hit) begin
                    startFill = 1'b1;
                    nextState = FILL;
                end
            end
            FILL: begin
                MemReq  = 1'b1;
                MemAddr = {fillTag, count, 2'b00};
                // Flush outranks an ack arriving in the same cycle.
                if (Flush) begin
                    clearValid = 1'b1;
                    nextState  = IDLE;
                end else if (MemAck) begin
                    wordAck = 1'b1;
                    if (count == IdxW'(LineWords - 1)) begin
                        lastWord  = 1'b1;
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // NOTE: all state registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count   <= '0;
            fillTag <= '0;
            tagReg  <= '0;
            valid   <= 1'b0;
        end else if (clearValid) begin
            valid <= 1'b0;
            count <= '0;
        end else if (startFill) begin
            fillTag <= addrTag;
            count   <= '0;
            valid   <= 1'b0;
        end else if (wordAck) begin
            count <= count + IdxW'(1);
            if (lastWord) begin
                tagReg <= fillTag;
                valid  <= 1'b1;
            end
        end
    end

    // NOTE: the line array is deliberately not reset; the valid bit guards every read of it.
    always_ff @(posedge clock) begin
        if (wordAck) begin
            lineMem[count] <= MemData;
        end
    end

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Self-checking bench for ins_fetch_ctrl: directed scenarios with literal
// expectations plus a randomized run against a line-level behavioural model.
module tb_ins_fetch_ctrl;

    localparam int dataW     = 32;
    localparam int LineWords = 4;
    localparam int LineBytes = LineWords * 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [dataW-1:0] ProgAddr = '0;
    logic             Flush = 1'b0;
    logic             MemAck = 1'b0;
    logic [dataW-1:0] MemData;
    logic [dataW-1:0] junk = '0;
    logic             MemReq;
    logic [dataW-1:0] MemAddr;
    logic [dataW-1:0] Instruction;
    logic             InsValid;
    logic             InsCacheStall;

    int passCount  = 0;
    int checkCount = 0;

    ins_fetch_ctrl #(.dataW(dataW), .LineWords(LineWords)) dut (
        .clock        (clock),
        .reset        (reset),
        .ProgAddr     (ProgAddr),
        .Flush        (Flush),
        .MemAck       (MemAck),
        .MemData      (MemData),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .Instruction  (Instruction),
        .InsValid     (InsValid),
        .InsCacheStall(InsCacheStall)
    );

    always #5 clock = ~clock;

    // Instruction memory contents are a pure function of the word address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h44;
            default: return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
        endcase
    endfunction

    assign MemData = MemReq ? memWord(MemAddr) : junk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Line-level model: which line base is buffered, and how far a refill has progressed.
    bit          busy = 1'b0;
    bit          cached = 1'b0;
    logic [31:0] fillBase = '0;
    logic [31:0] cachedBase = '0;
    int          words = 0;

    function automatic logic [31:0] lineOf(input logic [31:0] a);
        return a & ~32'(LineBytes - 1);
    endfunction

    function automatic bit modelHit();
        return cached && !busy && (lineOf(ProgAddr) == cachedBase);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            cached <= 1'b0;
            words  <= 0;
        end else if (busy) begin
            if (Flush) begin
                busy <= 1'b0;
            end else if (MemAck) begin
                words <= words + 1;
                if (words == LineWords - 1) begin
                    busy       <= 1'b0;
                    cached     <= 1'b1;
                    cachedBase <= fillBase;
                end
            end
        end else if (Flush) begin
            cached <= 1'b0;
        end else if (!modelHit()) begin
            busy     <= 1'b1;
            cached   <= 1'b0;
            fillBase <= lineOf(ProgAddr);
            words    <= 0;
        end
    end

    // Compare every cycle, mid-low-phase, once inputs and combinational outputs settled.
    always begin
        @(negedge clock);
        #2;
        check("cmp_MemReq", 32'(MemReq), 32'(busy));
        check("cmp_MemAddr", MemAddr, busy ? fillBase + 32'(4 * words) : 32'h0);
        check("cmp_InsValid", 32'(InsValid), 32'(modelHit()));
        check("cmp_InsCacheStall", 32'(InsCacheStall), 32'(!modelHit()));
        check("cmp_Instruction", Instruction, modelHit() ? memWord(ProgAddr & ~32'h3) : 32'h0);
    end

    task automatic drive(input logic rst, input logic [31:0] pa, input logic fl, input logic ack);
        @(negedge clock);
        reset    = rst;
        ProgAddr = pa;
        Flush    = fl;
        MemAck   = ack;
        junk     = $urandom;
        #2;
    endtask

    initial begin
        logic [31:0] seqAddr [3];
        logic [31:0] seqIns  [3];
        logic [31:0] pa;
        int          stallCyc, acks;
        bit          gotHit;

        seqAddr = '{32'h4, 32'h8, 32'hC};
        seqIns  = '{32'h22, 32'h33, 32'h44};

        #1 reset = 1'b1;
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 1);
        check("rst_MemReq", 32'(MemReq), 0);
        check("rst_MemAddr", MemAddr, 0);
        check("rst_InsValid", 32'(InsValid), 0);
        check("rst_Instruction", Instruction, 0);
        check("rst_Stall", 32'(InsCacheStall), 1);

        // Cold start: miss cycle, four fill cycles, hit on the fifth.
        drive(0, 0, 0, 1);
        check("cold_c0_stall", 32'(InsCacheStall), 1);
        check("cold_c0_req", 32'(MemReq), 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1);
            check("cold_addr", MemAddr, 32'(4 * i));
            check("cold_stall", 32'(InsCacheStall), 1);
        end
        drive(0, 0, 0, 1);
        check("cold_c5_valid", 32'(InsValid), 1);
        check("cold_c5_ins", Instruction, 32'h11);

        for (int i = 0; i < 3; i++) begin
            drive(0, seqAddr[i], 0, 1'($urandom_range(0, 1)));
            check("seq_ins", Instruction, seqIns[i]);
            check("seq_stall", 32'(InsCacheStall), 0);
            check("seq_req", 32'(MemReq), 0);
        end

        // Line crossing; the PC wanders back to the old line during the fill.
        drive(0, 32'h10, 0, 1);
        check("cross_miss", 32'(InsCacheStall), 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 0, 1);
            check("cross_addr", MemAddr, 32'h10 + 32'(4 * i));
            check("cross_old_invalid", 32'(InsValid), 0);
        end
        drive(0, 32'h14, 0, 1);
        check("cross_hit", 32'(InsValid), 1);
        check("cross_ins", Instruction, memWord(32'h14));

        // Slow memory: ack every third cycle counted from miss detection.
        stallCyc = 0;
        acks     = 0;
        for (int c = 0; c < 40; c++) begin
            drive(0, 32'h40, 0, (c % 3) == 0);
            if (!InsCacheStall) break;
            stallCyc++;
            if (MemReq && MemAck) acks++;
        end
        check("slow_stall_cycles", 32'(stallCyc), 32'(1 + 3 * LineWords));
        check("slow_acks", 32'(acks), 32'(LineWords));

        // Flush while the second word is being fetched.
        drive(0, 32'h80, 0, 1);
        drive(0, 32'h80, 0, 1);
        check("flush_w0_addr", MemAddr, 32'h80);
        drive(0, 32'h80, 1, 1);
        check("flush_w1_addr", MemAddr, 32'h84);
        drive(0, 32'h80, 0, 0);
        check("flush_req_low", 32'(MemReq), 0);
        check("flush_invalid", 32'(InsValid), 0);
        drive(0, 32'h80, 0, 1);
        check("flush_restart_addr", MemAddr, 32'h80);
        gotHit = 1'b0;
        for (int c = 0; c < 20 && !gotHit; c++) begin
            drive(0, 32'h80, 0, 1);
            gotHit = InsValid;
        end
        check("flush_refill_hit", 32'(gotHit), 1);

        // Reset asynchronously in the middle of the third fill word.
        drive(0, 32'hC0, 0, 1);
        drive(0, 32'hC0, 0, 1);
        drive(0, 32'hC0, 0, 1);
        drive(0, 32'hC0, 0, 1);
        check("rstfill_c2_addr", MemAddr, 32'hC8);
        #1 reset = 1'b1;
        #1;
        check("rstfill_req_now", 32'(MemReq), 0);
        check("rstfill_addr_now", MemAddr, 0);
        drive(1, 32'hC0, 0, 1);
        drive(0, 32'hC0, 0, 1);
        check("rstfill_miss_req", 32'(MemReq), 0);
        drive(0, 32'hC0, 0, 1);
        check("rstfill_restart_addr", MemAddr, 32'hC0);

        // Randomized traffic with locality, flushes, sparse acks and rare resets.
        pa = 32'h0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) pa = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            drive($urandom_range(0, 99) == 0, pa, $urandom_range(0, 19) == 0,
                  1'($urandom_range(0, 1)));
        end
        drive(0, pa, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
